// File: rtl/hwt_pkg.sv
// Shared types and constants for the HWT cone self-test sequencer.
// The golden function is the reference behaviour of the untampered cone.
package hwt_pkg;

  localparam int unsigned VEC_W   = 4;
  localparam int unsigned NUM_VEC = 16;

  localparam int unsigned IDX_A = 3;
  localparam int unsigned IDX_B = 2;
  localparam int unsigned IDX_C = 1;
  localparam int unsigned IDX_D = 0;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } hwt_state_e;

  function automatic logic golden(input logic [VEC_W-1:0] vec);
    return vec[IDX_D] & ((vec[IDX_A] & vec[IDX_B]) | vec[IDX_C]);
  endfunction

endpackage

// File: rtl/hwt_golden_ref.sv
// Combinational reference model of the fault-free cone: Y = D & ((A & B) | C).
module hwt_golden_ref
  import hwt_pkg::*;
(
  input  logic [VEC_W-1:0] vec_i,
  output logic             exp_o
);

  assign exp_o = golden(vec_i);

endmodule

// File: rtl/hwt_scan_sequencer.sv
// Sweeps all cone input vectors, compares the sampled cone output against the golden
// function and reports pass/fail, a saturating mismatch count and the first failing vector.
module hwt_scan_sequencer
  import hwt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned CNT_W         = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             y_in,
  output logic [VEC_W-1:0] vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_valid
);

  localparam int unsigned SetW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned PassW = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [SetW-1:0]  SettleLast = SetW'(SETTLE_CYCLES - 1);
  localparam logic [PassW-1:0] PassLast   = PassW'(PASSES - 1);
  localparam logic [CNT_W-1:0] CntMax     = '1;
  localparam logic [VEC_W-1:0] VecLast    = '1;

  hwt_state_e       state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [SetW-1:0]  settle_q, settle_d;
  logic [PassW-1:0] pass_idx_q, pass_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VEC_W-1:0] ffv_q, ffv_d;
  logic             ffvalid_q, ffvalid_d;

  logic exp_y;
  logic miscompare;

  hwt_golden_ref u_golden (
    .vec_i (vec_q),
    .exp_o (exp_y)
  );

  assign miscompare = y_in ^ exp_y;

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    settle_d   = settle_q;
    pass_idx_d = pass_idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    cnt_d      = cnt_q;
    ffv_d      = ffv_q;
    ffvalid_d  = ffvalid_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StSettle;
          vec_d      = '0;
          settle_d   = '0;
          pass_idx_d = '0;
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          cnt_d      = '0;
          ffv_d      = '0;
          ffvalid_d  = 1'b0;
        end
      end

      StSettle: begin
        if (abort) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          settle_d = settle_q + 1'b1;
          if (settle_q == SettleLast) begin
            state_d = StSample;
          end
        end
      end

      StSample: begin
        // An abort in the sample cycle drops that cycle's comparison entirely.
        if (abort) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          if (miscompare) begin
            if (cnt_q != CntMax) begin
              cnt_d = cnt_q + 1'b1;
            end
            if (!ffvalid_q) begin
              ffv_d     = vec_q;
              ffvalid_d = 1'b1;
            end
          end
          if (vec_q == VecLast && pass_idx_q == PassLast) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (cnt_d == '0);
          end else begin
            vec_d    = vec_q + 1'b1;
            settle_d = '0;
            state_d  = StSettle;
            if (vec_q == VecLast) begin
              pass_idx_d = pass_idx_q + 1'b1;
            end
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      vec_q      <= '0;
      settle_q   <= '0;
      pass_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      cnt_q      <= '0;
      ffv_q      <= '0;
      ffvalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      settle_q   <= settle_d;
      pass_idx_q <= pass_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      cnt_q      <= cnt_d;
      ffv_q      <= ffv_d;
      ffvalid_q  <= ffvalid_d;
    end
  end

  assign vec_out          = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign mismatch_cnt     = cnt_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_hwt_scan_sequencer.sv
// Directed bench: golden truth table, table-driven fault scenarios and hand-written
// sequences for abort, restart, start re-pulse, multi-pass saturation and mid-run reset.
module tb_hwt_scan_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  int   mode = 0;  // 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 trojan at 4'hE

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Bench's own cone model, written independently of the RTL.
  function automatic logic cone_y(input int m, input logic [3:0] v);
    logic g;
    g = v[0] & ((v[3] & v[2]) | v[1]);
    case (m)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return g ^ (v == 4'hE);
      default: return g;
    endcase
  endfunction

  logic [3:0] vec1, vec2, vec3, ffv1, ffv2, ffv3;
  logic       y1, y2, y3;
  logic       busy1, busy2, busy3, done1, done2, done3, pass1, pass2, pass3;
  logic       ffvalid1, ffvalid2, ffvalid3;
  logic [4:0] cnt1, cnt2, cnt3;

  always_comb y1 = cone_y(mode, vec1);
  always_comb y2 = cone_y(mode, vec2);
  always_comb y3 = cone_y(mode, vec3);

  hwt_scan_sequencer #(.SETTLE_CYCLES(2), .PASSES(1), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y_in(y1),
    .vec_out(vec1), .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(cnt1),
    .first_fail_vec(ffv1), .first_fail_valid(ffvalid1)
  );

  hwt_scan_sequencer #(.SETTLE_CYCLES(2), .PASSES(2), .CNT_W(5)) dut_p2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y_in(y2),
    .vec_out(vec2), .busy(busy2), .done(done2), .pass(pass2), .mismatch_cnt(cnt2),
    .first_fail_vec(ffv2), .first_fail_valid(ffvalid2)
  );

  hwt_scan_sequencer #(.SETTLE_CYCLES(2), .PASSES(3), .CNT_W(5)) dut_p3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y_in(y3),
    .vec_out(vec3), .busy(busy3), .done(done3), .pass(pass3), .mismatch_cnt(cnt3),
    .first_fail_vec(ffv3), .first_fail_valid(ffvalid3)
  );

  logic [3:0] gold_vec;
  logic       gold_exp;

  hwt_golden_ref u_gold (
    .vec_i (gold_vec),
    .exp_o (gold_exp)
  );

  typedef struct {
    logic [3:0] vec;
    logic       exp;
  } gold_rec_t;

  typedef struct {
    string      name;
    int         mode;
    logic       with_abort;
    logic [4:0] cnt;
    logic [3:0] ffv;
    logic       ffvalid;
    logic       pass;
  } scen_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start(input logic with_abort);
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = with_abort;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic run_full(input scen_t s);
    int   busy_cycles;
    logic saw_done;
    mode = s.mode;
    pulse_start(s.with_abort);
    busy_cycles = 0;
    saw_done    = 1'b0;
    for (int i = 0; i < 200 && !saw_done; i++) begin
      @(negedge clk);
      if (busy1) busy_cycles++;
      if (done1) saw_done = 1'b1;
    end
    check({s.name, " done seen"}, saw_done, 1);
    check({s.name, " busy cycles"}, busy_cycles, 48);
    check({s.name, " busy low at done"}, busy1, 0);
    check({s.name, " pass"}, pass1, s.pass);
    check({s.name, " mismatch_cnt"}, cnt1, s.cnt);
    check({s.name, " first_fail_valid"}, ffvalid1, s.ffvalid);
    check({s.name, " first_fail_vec"}, ffv1, s.ffv);
    @(negedge clk);
    check({s.name, " done one cycle"}, done1, 0);
    check({s.name, " vec_out held"}, vec1, 4'hF);
    check({s.name, " pass held"}, pass1, s.pass);
  endtask

  gold_rec_t  gtab[16];
  scen_t      stab[4];
  logic [15:0] tt;

  initial begin
    int   bc;
    logic saw, saw2, saw3, found;

    tt = 16'hA888;  // cone is 1 only at vectors 3, 7, B, D, F
    for (int i = 0; i < 16; i++) begin
      gtab[i].vec = 4'(i);
      gtab[i].exp = tt[i];
    end
    stab[0] = '{"good",    0, 1'b0, 5'd0,  4'h0, 1'b0, 1'b1};
    stab[1] = '{"stuck0",  1, 1'b0, 5'd5,  4'h3, 1'b1, 1'b0};
    stab[2] = '{"stuck1",  2, 1'b0, 5'd11, 4'h0, 1'b1, 1'b0};
    stab[3] = '{"trojanE", 3, 1'b1, 5'd1,  4'hE, 1'b1, 1'b0};

    for (int i = 0; i < 16; i++) begin
      gold_vec = gtab[i].vec;
      #1;
      check($sformatf("golden[%0h]", gtab[i].vec), gold_exp, gtab[i].exp);
    end

    // Reset state, checked both during and just after reset.
    @(negedge clk);
    check("rst busy", busy1, 0);
    check("rst vec_out", vec1, 0);
    check("rst pass", pass1, 0);
    do_reset();
    check("post-rst done", done1, 0);
    check("post-rst mismatch_cnt", cnt1, 0);
    check("post-rst first_fail", {ffvalid1, ffv1}, 0);

    for (int i = 0; i < 4; i++) run_full(stab[i]);

    // Abort in vector 7's sample cycle under stuck-at-0; the vec 7 miscompare is dropped.
    mode = 1;
    pulse_start(1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (vec1 == 4'h7) found = 1'b1;
    end
    check("abort reached vec7", found, 1);
    @(negedge clk);
    @(negedge clk);
    check("abort busy before", busy1, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", busy1, 0);
    check("abort pass", pass1, 0);
    check("abort mismatch_cnt", cnt1, 1);
    check("abort first_fail_vec", ffv1, 4'h3);
    check("abort first_fail_valid", ffvalid1, 1);
    saw = done1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      saw = saw | done1 | busy1;
    end
    check("abort no done/busy", saw, 0);

    // Fresh start after abort clears results and completes normally.
    run_full(stab[0]);

    // Start re-pulsed mid-run must not disturb timing.
    mode = 0;
    pulse_start(1'b0);
    bc  = 0;
    saw = 1'b0;
    for (int i = 0; i < 200 && !saw; i++) begin
      @(negedge clk);
      if (busy1) bc++;
      if (done1) saw = 1'b1;
      start = (i == 10);
    end
    start = 1'b0;
    check("repulse done seen", saw, 1);
    check("repulse busy cycles", bc, 48);
    check("repulse pass", pass1, 1);

    // Multi-pass stuck-at-1: 22 for two passes, 33 saturating to 31 for three.
    do_reset();
    mode = 2;
    pulse_start(1'b0);
    saw2 = 1'b0;
    saw3 = 1'b0;
    for (int i = 0; i < 400 && !saw3; i++) begin
      @(negedge clk);
      if (done2) saw2 = 1'b1;
      if (done3) saw3 = 1'b1;
    end
    check("p2 done seen", saw2, 1);
    check("p3 done seen", saw3, 1);
    check("p2 mismatch_cnt", cnt2, 22);
    check("p3 mismatch_cnt sat", cnt3, 31);
    check("p2 pass", pass2, 0);
    check("p3 first_fail_vec", {ffvalid3, ffv3}, 5'h10);

    // Async reset mid-run takes effect without a clock edge.
    pulse_start(1'b0);
    repeat (20) @(negedge clk);
    check("pre-rst busy", busy1, 1);
    check("pre-rst mismatch_cnt nonzero", cnt1 != 0, 1);
    rst_n = 1'b0;
    #1;
    check("midrst busy", busy1, 0);
    check("midrst vec_out", vec1, 0);
    check("midrst mismatch_cnt", cnt1, 0);
    check("midrst first_fail_valid", ffvalid1, 0);
    saw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      saw = saw | done1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      saw = saw | done1 | busy1;
    end
    check("midrst no done", saw, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
